// File: rtl/sync_updown_counter.sv
// sync_updown_counter: modulo-(MAX+1) up/down counter with clipped parallel load,
// wrap/one-shot modes and a cascade carry. Define SYNC_UDC_PRESCALE_EN to add an enable prescaler.
module sync_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX       = (1 << WIDTH) - 1,
  parameter int RESET_VAL = MAX,
  parameter int PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MAX_X   = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

  if (WIDTH < 2 || MAX < 0 || MAX > (1 << WIDTH) - 1 ||
      RESET_VAL < 0 || RESET_VAL > MAX || PRESCALE < 2) begin : g_bad_params
    $error("sync_updown_counter: illegal parameter combination");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             tick;
  logic             step;
  logic             at_term;

`ifdef SYNC_UDC_PRESCALE_EN
  localparam int           PW    = $clog2(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Prescaler free-runs on enabled, non-halted cycles; load realigns its phase.
  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (en && !done_q) begin
      presc_d = (presc_q == PLAST) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = (presc_q == PLAST);
`else
  assign tick = 1'b1;
`endif

  assign step    = en && !load && !done_q && tick;
  assign at_term = up ? (count_q == MAX_V) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    if (load) begin
      count_d = ({1'b0, load_val} > MAX_X) ? MAX_V : load_val;
      done_d  = 1'b0;
    end else if (step) begin
      if (!at_term) begin
        count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end else if (oneshot) begin
        done_d = 1'b1;
      end else begin
        count_d = up ? '0 : MAX_V;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_V;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Reset gating keeps carry low while held, even if RESET_VAL sits at a terminal.
  assign carry = step && at_term && !reset;
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench for sync_updown_counter (WIDTH=4, MAX=9, RESET_VAL=9): directed vectors
// plus a per-cycle comparison against a modulo-arithmetic reference model.
module tb_sync_updown_counter;

  localparam int W  = 4;
  localparam int MX = 9;
  localparam int RV = 9;
  localparam int PS = 4;
`ifdef SYNC_UDC_PRESCALE_EN
  localparam int PRE = PS;
`else
  localparam int PRE = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         en, up, oneshot, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         carry, done;

  int checks   = 0;
  int failures = 0;

  sync_updown_counter #(
    .WIDTH(W), .MAX(MX), .RESET_VAL(RV), .PRESCALE(PS)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .oneshot(oneshot),
    .load(load), .load_val(load_val), .count(count), .carry(carry), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: counting is (count + 1) or (count + MAX) modulo MAX+1.
  int m_count = RV;
  int m_pre   = 0;
  bit m_done  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count <= RV;
      m_done  <= 1'b0;
      m_pre   <= 0;
    end else if (load) begin
      m_count <= (int'(load_val) > MX) ? MX : int'(load_val);
      m_done  <= 1'b0;
      m_pre   <= 0;
    end else if (en && !m_done) begin
      m_pre <= (m_pre + 1) % PRE;
      if (m_pre == PRE - 1) begin
        if (oneshot && (up ? m_count == MX : m_count == 0))
          m_done <= 1'b1;
        else
          m_count <= (m_count + (up ? 1 : MX)) % (MX + 1);
      end
    end
  end

  function automatic bit model_carry();
    return !reset && !load && en && !m_done && (m_pre == PRE - 1) &&
           (up ? m_count == MX : m_count == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Inputs change at negedge+1; the model comparison runs at negedge+3.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("model_count", 32'(count), 32'(m_count));
      chk("model_done",  32'(done),  32'(m_done));
      chk("model_carry", 32'(carry), 32'(model_carry()));
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  int seq [12] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
`ifdef SYNC_UDC_PRESCALE_EN
  int pseq_a [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
  int pseq_b [4] = '{2, 2, 2, 3};
`endif

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b0; oneshot = 1'b0; load = 1'b0; load_val = '0;
    #1 reset = 1'b1;
    nxt();
    chk("rst_count", 32'(count), 9);
    chk("rst_done",  32'(done),  0);
    chk("rst_carry", 32'(carry), 0);
    en = 1'b1; up = 1'b1; #1;
    chk("rst_carry_gated", 32'(carry), 0);
    nxt();
    chk("rst_hold_count", 32'(count), 9);

`ifndef SYNC_UDC_PRESCALE_EN
    reset = 1'b0; up = 1'b0; #1;
    for (int i = 0; i < 12; i++) begin
      chk("down_wrap_count", 32'(count), 32'(seq[i]));
      chk("down_wrap_carry", 32'(carry), (seq[i] == 0) ? 1 : 0);
      nxt();
    end
    chk("down_wrap_end", 32'(count), 7);

    load = 1'b1; load_val = 4'd13; #1;
    chk("load_carry", 32'(carry), 0);
    nxt();
    chk("load_clip_13", 32'(count), 9);
    load = 1'b0; up = 1'b1; #1;
    chk("up_wrap_carry", 32'(carry), 1);
    nxt();
    chk("up_wrap_count", 32'(count), 0);
    chk("up_zero_carry", 32'(carry), 0);

    oneshot = 1'b1; load = 1'b1; load_val = 4'd7;
    nxt();
    chk("os_load7", 32'(count), 7);
    load = 1'b0;
    nxt();
    chk("os_8", 32'(count), 8);
    nxt();
    chk("os_9", 32'(count), 9);
    chk("os_9_done", 32'(done), 0);
    chk("os_term_carry", 32'(carry), 1);
    nxt();
    chk("os_hold", 32'(count), 9);
    chk("os_done", 32'(done), 1);
    chk("os_halt_carry", 32'(carry), 0);
    up = 1'b0;
    nxt();
    chk("os_dir_ignored", 32'(count), 9);
    chk("os_dir_done", 32'(done), 1);
    oneshot = 1'b0; up = 1'b1; #1;
    chk("os_mode_carry", 32'(carry), 0);
    nxt();
    chk("os_mode_hold", 32'(count), 9);
    chk("os_mode_done", 32'(done), 1);
    load = 1'b1; load_val = 4'd2;
    nxt();
    chk("os_reload", 32'(count), 2);
    chk("os_reload_done", 32'(done), 0);

    load_val = 4'd5;
    nxt();
    chk("ld5", 32'(count), 5);
    load_val = 4'd3; #1;
    chk("ld_en_carry", 32'(carry), 0);
    nxt();
    chk("ld_beats_step", 32'(count), 3);
    load = 1'b0;
    nxt();
    chk("after_ld_step", 32'(count), 4);

    reset = 1'b1; #1;
    chk("async_rst_count", 32'(count), 9);
    chk("async_rst_done",  32'(done),  0);
    chk("async_rst_carry", 32'(carry), 0);
    nxt();
    chk("async_rst_hold", 32'(count), 9);
    reset = 1'b0; up = 1'b0;
    nxt();
    chk("post_rst_step", 32'(count), 8);

    load = 1'b1; load_val = 4'd9;
    nxt();
    chk("load_max", 32'(count), 9);
    load_val = 4'd15;
    nxt();
    chk("load_clip_15", 32'(count), 9);
    load_val = 4'd0;
    nxt();
    chk("load_zero", 32'(count), 0);
    load = 1'b0; oneshot = 1'b1; up = 1'b0; #1;
    chk("os_down_carry", 32'(carry), 1);
    nxt();
    chk("os_down_hold", 32'(count), 0);
    chk("os_down_done", 32'(done), 1);
    load = 1'b1; load_val = 4'd4;
    nxt();
    load = 1'b0; en = 1'b0;
    nxt();
    chk("en_low_hold", 32'(count), 4);
`else
    reset = 1'b0; load = 1'b1; load_val = 4'd0;
    nxt();
    chk("ps_load0", 32'(count), 0);
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      nxt();
      chk("ps_rate", 32'(count), 32'(pseq_a[k]));
    end
    nxt();
    nxt();
    load = 1'b1; load_val = 4'd2;
    nxt();
    chk("ps_reload", 32'(count), 2);
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("ps_phase_clear", 32'(count), 32'(pseq_b[k]));
    end
`endif

    nxt();
    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
